// File: rtl/prom_top_level.sv
// PROM-Pong top: PWM-DAC successive-approximation ADC plus score-digit decoder.
// Build option PROM_SEG_HEX_EN adds hex glyphs A..F for bcd 10..15.
module prom_top_level #(
  parameter int ADC_BITS       = 7,
  parameter int SETTLE_PERIODS = 4
) (
  input  logic                CLK,
  input  logic                Reset,
  input  logic                gtRef,
  output logic                DACout,
  output logic [ADC_BITS-1:0] ADCout,
  input  logic [3:0]          bcd,
  output logic [6:0]          segOut
);

  localparam int PW = (SETTLE_PERIODS > 1) ?
                      $clog2(SETTLE_PERIODS) : 1;
  localparam int IW = (ADC_BITS > 1) ? $clog2(ADC_BITS) : 1;

  localparam logic [ADC_BITS-1:0] MSB_CODE =
    {1'b1, {(ADC_BITS-1){1'b0}}};
  localparam logic [ADC_BITS-1:0] PWM_MAX  = '1;
  localparam logic [PW-1:0]       PER_LAST = PW'(SETTLE_PERIODS-1);
  localparam logic [IW-1:0]       IDX_TOP  = IW'(ADC_BITS-1);

  logic                gt_meta;
  logic                gt_sync;
  logic [ADC_BITS-1:0] pwm_cnt;
  logic [PW-1:0]       per_cnt;
  logic [IW-1:0]       bit_idx;
  logic [ADC_BITS-1:0] trial_code;

  logic [PW-1:0]       per_nxt;
  logic [IW-1:0]       idx_nxt;
  logic [ADC_BITS-1:0] code_nxt;
  logic [ADC_BITS-1:0] bit_mask;
  logic [ADC_BITS-1:0] decided;
  logic                period_end;
  logic                trial_end;
  logic                conv_end;

  // gtRef is asynchronous to CLK
  always_ff @(posedge CLK or negedge Reset) begin
    if (!Reset) begin
      gt_meta <= 1'b0;
      gt_sync <= 1'b0;
    end else begin
      gt_meta <= gtRef;
      gt_sync <= gt_meta;
    end
  end

  always_ff @(posedge CLK or negedge Reset) begin
    if (!Reset) begin
      pwm_cnt    <= '0;
      per_cnt    <= '0;
      bit_idx    <= IDX_TOP;
      trial_code <= MSB_CODE;
    end else begin
      pwm_cnt    <= pwm_cnt + 1'b1;
      per_cnt    <= per_nxt;
      bit_idx    <= idx_nxt;
      trial_code <= code_nxt;
    end
  end

  always_comb begin
    period_end = (pwm_cnt == PWM_MAX);
    trial_end  = period_end && (per_cnt == PER_LAST);
    conv_end   = trial_end && (bit_idx == '0);
    bit_mask   = ADC_BITS'(1) << bit_idx;
    decided    = gt_sync ? trial_code : (trial_code & ~bit_mask);
  end

  always_comb begin
    per_nxt  = per_cnt;
    idx_nxt  = bit_idx;
    code_nxt = trial_code;
    if (period_end)
      per_nxt = (per_cnt == PER_LAST) ? '0 : per_cnt + PW'(1);
    if (conv_end) begin
      idx_nxt  = IDX_TOP;
      code_nxt = MSB_CODE;
    end else if (trial_end) begin
      idx_nxt  = bit_idx - 1'b1;
      code_nxt = decided | (bit_mask >> 1);
    end
  end

  // Result is published only once the LSB has been decided
  always_ff @(posedge CLK or negedge Reset) begin
    if (!Reset) begin
      DACout <= 1'b0;
      ADCout <= '0;
    end else begin
      DACout <= (pwm_cnt < trial_code);
      if (conv_end)
        ADCout <= decided;
    end
  end

  always_comb begin
    segOut = 7'h7F;
    case (bcd)
      4'd0:  segOut = 7'h40;
      4'd1:  segOut = 7'h79;
      4'd2:  segOut = 7'h24;
      4'd3:  segOut = 7'h30;
      4'd4:  segOut = 7'h19;
      4'd5:  segOut = 7'h12;
      4'd6:  segOut = 7'h02;
      4'd7:  segOut = 7'h78;
      4'd8:  segOut = 7'h00;
      4'd9:  segOut = 7'h10;
`ifdef PROM_SEG_HEX_EN
      4'd10: segOut = 7'h08;
      4'd11: segOut = 7'h03;
      4'd12: segOut = 7'h46;
      4'd13: segOut = 7'h21;
      4'd14: segOut = 7'h06;
      4'd15: segOut = 7'h0E;
`endif
      default: segOut = 7'h7F;
    endcase
  end

endmodule

// File: tb/tb_prom_top_level.sv
// Directed bench for prom_top_level: SAR conversions, PWM duty,
// reset behaviour and the seven-segment decoder.
module tb_prom_top_level;

  logic       CLK;
  logic       Reset;
  logic       gtRef;
  logic       DACout;
  logic [6:0] ADCout;
  logic [3:0] bcd;
  logic [6:0] segOut;

  int checks = 0;
  int fails  = 0;
  int dac_hi [7];

  prom_top_level dut (
    .CLK    (CLK),
    .Reset  (Reset),
    .gtRef  (gtRef),
    .DACout (DACout),
    .ADCout (ADCout),
    .bcd    (bcd),
    .segOut (segOut)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Drives gtRef as a comparator against a fixed analogue target,
  // following the trial sequence one 512-clock trial at a time.
  task automatic run_conv(input logic [6:0] target,
                          input logic [6:0] prev,
                          input logic [6:0] exp);
    logic [6:0] res;
    logic [6:0] trial;
    res = '0;
    for (int i = 6; i >= 0; i--) begin
      trial = res | (7'd1 << i);
      gtRef = (target >= trial);
      dac_hi[i] = 0;
      for (int e = 0; e < 512; e++) begin
        @(posedge CLK);
        #1;
        if (e < 128 && DACout === 1'b1) dac_hi[i]++;
        if (i == 3 && e == 0) chk("adc_hold_mid", ADCout, prev);
        if (i == 0 && e == 510) chk("adc_hold_end", ADCout, prev);
      end
      if (gtRef) res = trial;
    end
    chk("adc_result", ADCout, exp);
  endtask

  logic [6:0] seg_exp [16];

  initial begin
    seg_exp[0]  = 7'h40; seg_exp[1]  = 7'h79;
    seg_exp[2]  = 7'h24; seg_exp[3]  = 7'h30;
    seg_exp[4]  = 7'h19; seg_exp[5]  = 7'h12;
    seg_exp[6]  = 7'h02; seg_exp[7]  = 7'h78;
    seg_exp[8]  = 7'h00; seg_exp[9]  = 7'h10;
`ifdef PROM_SEG_HEX_EN
    seg_exp[10] = 7'h08; seg_exp[11] = 7'h03;
    seg_exp[12] = 7'h46; seg_exp[13] = 7'h21;
    seg_exp[14] = 7'h06; seg_exp[15] = 7'h0E;
`else
    for (int k = 10; k < 16; k++) seg_exp[k] = 7'h7F;
`endif

    Reset = 1'b1;
    gtRef = 1'b0;
    bcd   = 4'd0;
    #2;
    Reset = 1'b0;
    #1;
    chk("rst_adc", ADCout, 7'h00);
    chk("rst_dac", DACout, 1'b0);

    for (int k = 0; k < 16; k++) begin
      bcd = 4'(k);
      #1;
      chk($sformatf("seg_%0d", k), segOut, seg_exp[k]);
    end

    @(negedge CLK);
    @(negedge CLK);
    Reset = 1'b1;

    run_conv(7'h00, 7'h00, 7'h00);
    chk("dac_msb_duty", dac_hi[6], 64);
    chk("dac_lsb_duty", dac_hi[0], 1);

    run_conv(7'h7F, 7'h00, 7'h7F);
    chk("dac_ff_duty", dac_hi[0], 127);
    run_conv(7'h7F, 7'h7F, 7'h7F);

    run_conv(7'h55, 7'h7F, 7'h55);
    chk("dac_55_msb", dac_hi[6], 64);
    run_conv(7'h2A, 7'h55, 7'h2A);

    // abort part-way into the next conversion
    gtRef = 1'b1;
    repeat (700) @(posedge CLK);
    #1;
    chk("pre_abort_adc", ADCout, 7'h2A);
    Reset = 1'b0;
    #2;
    chk("abort_adc", ADCout, 7'h00);
    chk("abort_dac", DACout, 1'b0);
    repeat (3) @(negedge CLK);
    chk("held_adc", ADCout, 7'h00);
    Reset = 1'b1;
    run_conv(7'h55, 7'h00, 7'h55);

    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end

endmodule

// File: doc/prom_top_level.md
Name: prom_top_level

Overview:
- Top level of the PROM-Pong CPLD.
- Implements a 7-bit successive-approximation ADC built from a 1-bit PWM DAC (DACout, driving an external RC filter) and an external analogue comparator (gtRef).
- Also contains an independent combinational BCD-to-seven-segment decoder for the score display.
- ADCout feeds the paddle-position logic elsewhere in the design.

Parameters:
- ADC_BITS, 7, resolution of the SAR result and the PWM counter. The ADCout width follows it.
- SETTLE_PERIODS, 4, number of full PWM periods each bit trial lasts before gtRef is sampled (RC settling time).

Ports:
- CLK  input  1  system clock; all sequential logic is on the rising edge.
- Reset  input  1  asynchronous, active-low reset (0 = reset asserted).
- gtRef  input  1  comparator output, asynchronous to CLK; 1 = analogue input >= filtered DAC voltage.
- DACout  output  1  PWM DAC drive, registered.
- ADCout  output  ADC_BITS  last completed conversion result, registered.
- bcd  input  4  digit to display.
- segOut  output  7  segment drive, active-low; bit0=a, bit1=b, ..., bit6=g.

Behaviour:
- Reset asserted (Reset=0), asynchronously:
  - pwm_cnt=0, DACout=0, ADCout=0.
  - Synchroniser flops = 0.
  - trial code = 0x40 (MSB set, all else 0), bit index = 6, period counter = 0.
- gtRef passes through a 2-flop synchroniser before use.
- PWM counter:
  - ADC_BITS-bit free-running counter, wraps 127->0; one period = 128 clocks.
  - DACout <= (pwm_cnt < trial_code), registered.
  - Code 0 gives a constant 0; code 127 gives 127/128 duty.
- Bit trial, for bit i from MSB to LSB:
  - trial_code = result bits above i, bit i = 1, lower bits 0.
  - The trial lasts SETTLE_PERIODS*128 clocks, counted from pwm_cnt=0.
  - On the final clock of the trial (pwm_cnt=127 and last period), sample the synchronised gtRef:
    - 1: keep bit i.
    - 0: clear bit i.
  - Next cycle: advance to bit i-1 with its bit set in the trial code.
- Conversion end:
  - After the LSB decision, ADCout is loaded with the 7-bit result on the same edge.
  - The trial code then reinitialises to 0x40 and a new conversion starts immediately (continuous conversion).
  - Conversion time = ADC_BITS*SETTLE_PERIODS*128 = 3584 clocks at defaults. The first result appears 3584 clocks after reset release.
- ADCout holds its value between conversions and changes only at conversion end.
- Reset mid-conversion aborts the conversion; the partial result is discarded.
- gtRef changes mid-trial are ignored; only the sampled value counts.
- Seven-segment decoder:
  - Purely combinational, unaffected by Reset or CLK.
  - segOut = 7'h40,79,24,30,19,12,02,78,00,10 for bcd 0..9.
  - bcd 10..15 follow the optional feature.

Optional Feature:
- Macro PROM_SEG_HEX_EN.
- Defined: bcd 10..15 decode to hex glyphs A,b,C,d,E,F = 7'h08,03,46,21,06,0E.
- Undefined: bcd 10..15 give segOut = 7'h7F (all segments off, blank).
- Digits 0..9 are identical in both builds.

Test Plan:
- Hold Reset=0 mid-conversion -> ADCout=0 and DACout=0 immediately, without waiting for a clock edge. Release -> first ADCout update exactly 3584 clocks later.
- gtRef held 0 -> after first conversion ADCout=0x00. During the MSB trial, DACout is high 64 of every 128 clocks.
- gtRef held 1 -> ADCout=0x7F after each conversion. During the final trial (code 0x7F), DACout is high 127 of 128 clocks.
- Behavioural comparator model gtRef = (0x55 >= current trial code) -> ADCout=0x55. Change the target to 0x2A -> the next complete conversion gives 0x2A, and ADCout stays 0x55 until then.
- Sweep bcd 0..9 -> segOut = 40,79,24,30,19,12,02,78,00,10 (hex), with no clock required.
- bcd 10..15 -> with PROM_SEG_HEX_EN: 08,03,46,21,06,0E; without it: 7F for all six values.
